trigger_multiplicity_coinc: RTL and testbench

Downstream consumer of the per-channel trigger/scaler stage. It takes the positive- and negative-edge synchronous trigger bits (trig_p/trig_n) from NUM_CH channels and stretches each new hit into a programmable coincidence window. It counts how many channels are simultaneously open and issues a single-cycle multiplicity trigger when that count reaches a threshold, followed by a programmable holdoff. It produces the station-level trigger and its hit pattern for the readout and trigger-info path.

---
 rtl/trig_coinc_pkg.sv | 21 ++
 rtl/coinc_window_stretcher.sv | 53 +++++
 rtl/trigger_multiplicity_coinc.sv | 139 +++++++++++++
 tb/tb_trigger_multiplicity_coinc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_coinc_pkg.sv
// Shared definitions for the multiplicity coincidence trigger:
// FSM state encoding and an elaboration-time ceil(log2) helper.
package trig_coinc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } coinc_state_e;

    // Number of bits needed to represent v distinct values (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/coinc_window_stretcher.sv
// Per-channel hit edge detector and retriggerable coincidence window.
// A rising edge of the combined trigger level (re)loads the window
// down-counter; the channel is "open" while the counter is nonzero.
module coinc_window_stretcher
    import trig_coinc_pkg::*;
#(
    parameter int unsigned WINDOW_W = 4
) (
    input  logic                fast_clk_i,
    input  logic                rst_n_i,
    input  logic                hit_i,
    input  logic                clear_i,
    input  logic [WINDOW_W-1:0] window_i,
    output logic                open_o
);

    logic                r_hit_q;
    logic                r_hit_qq;
    logic [WINDOW_W-1:0] r_cnt;
    logic                w_new_hit;
    logic [WINDOW_W-1:0] w_load;

    assign w_new_hit = r_hit_q & ~r_hit_qq;
    assign w_load    = (window_i == '0) ? WINDOW_W'(1) : window_i;
    assign open_o    = (r_cnt != '0);

    // Two-stage hit pipeline for edge detection, so a multi-cycle
    // upstream pulse only opens one window.
    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hit_q  <= 1'b0;
            r_hit_qq <= 1'b0;
        end else begin
            r_hit_q  <= hit_i;
            r_hit_qq <= r_hit_q;
        end
    end

    // Window counter: clear has priority (trigger fired or disarmed);
    // an edge that is dropped by clear is consumed, not deferred.
    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_new_hit) begin
            r_cnt <= w_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/trigger_multiplicity_coinc.sv
// Station-level multiplicity trigger: stretches each channel's new hit
// into a coincidence window, counts open channels, and issues a single
// cycle trigger followed by a programmable holdoff when the count
// reaches the threshold.
module trigger_multiplicity_coinc
    import trig_coinc_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MULT_W    = 3,
    parameter int unsigned WINDOW_W  = 4,
    parameter int unsigned HOLDOFF_W = 8,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                 fast_clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_CH-1:0]    trig_p_i,
    input  logic [NUM_CH-1:0]    trig_n_i,
    input  logic                 enable_i,
    input  logic [WINDOW_W-1:0]  window_i,
    input  logic [MULT_W-1:0]    threshold_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    output logic                 trig_o,
    output logic [NUM_CH-1:0]    trig_pattern_o,
    output logic [MULT_W-1:0]    multiplicity_o,
    output logic                 busy_o,
    output logic [COUNT_W-1:0]   trig_count_o
);

    if (MULT_W < clog2(NUM_CH + 1)) begin : g_bad_mult_w
        $error("MULT_W is too narrow to hold a count of NUM_CH channels");
    end

    coinc_state_e         r_state;
    coinc_state_e         w_state_nxt;
    logic [NUM_CH-1:0]    w_open;
    logic [NUM_CH-1:0]    w_hit;
    logic                 w_clear;
    logic [MULT_W-1:0]    w_popcount;
    logic [MULT_W-1:0]    r_mult_q;
    logic                 w_fire_cond;
    logic [HOLDOFF_W-1:0] r_holdoff_cnt;
    logic [NUM_CH-1:0]    r_pattern;
    logic [MULT_W-1:0]    r_mult_lat;
    logic [COUNT_W-1:0]   r_count;

    assign w_hit   = trig_p_i | trig_n_i;
    // Windows are wiped in FIRE so the hits that caused this trigger
    // cannot fire again, and held empty while disarmed.
    assign w_clear = ~enable_i | (r_state == ST_FIRE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        coinc_window_stretcher #(
            .WINDOW_W (WINDOW_W)
        ) u_stretch (
            .fast_clk_i (fast_clk_i),
            .rst_n_i    (rst_n_i),
            .hit_i      (w_hit[g]),
            .clear_i    (w_clear),
            .window_i   (window_i),
            .open_o     (w_open[g])
        );
    end

    // Count of simultaneously open channels.
    always_comb begin
        w_popcount = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_popcount = w_popcount + MULT_W'(w_open[i]);
        end
    end

    // Register the multiplicity ahead of the threshold compare.
    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mult_q <= '0;
        end else begin
            r_mult_q <= w_popcount;
        end
    end

    assign w_fire_cond = enable_i && (threshold_i != '0) && (r_mult_q >= threshold_i);

    // FSM state register.
    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_fire_cond) w_state_nxt = ST_FIRE;
            ST_FIRE:    w_state_nxt = ST_HOLDOFF;
            ST_HOLDOFF: if (r_holdoff_cnt == '0) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        trig_o = (r_state == ST_FIRE);
        busy_o = (r_state != ST_IDLE);
    end

    // Holdoff counter: loaded in FIRE, counts down through HOLDOFF.
    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_holdoff_cnt <= '0;
        end else if (r_state == ST_FIRE) begin
            r_holdoff_cnt <= holdoff_i;
        end else if ((r_state == ST_HOLDOFF) && (r_holdoff_cnt != '0)) begin
            r_holdoff_cnt <= r_holdoff_cnt - 1'b1;
        end
    end

    // Latch trigger info and bump the saturating counter on IDLE->FIRE.
    always_ff @(posedge fast_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pattern  <= '0;
            r_mult_lat <= '0;
            r_count    <= '0;
        end else if ((r_state == ST_IDLE) && w_fire_cond) begin
            r_pattern  <= w_open;
            r_mult_lat <= r_mult_q;
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign trig_pattern_o = r_pattern;
    assign multiplicity_o = r_mult_lat;
    assign trig_count_o   = r_count;

endmodule

// File: tb/tb_trigger_multiplicity_coinc.sv
// Self-checking bench for trigger_multiplicity_coinc: directed scenarios
// with literal expectations plus randomized traffic against a time-based
// reference model (window close times, busy-until time).
module tb_trigger_multiplicity_coinc;

    localparam int NUM_CH    = 4;
    localparam int MULT_W    = 3;
    localparam int WINDOW_W  = 4;
    localparam int HOLDOFF_W = 8;
    localparam int COUNT_W   = 4;
    localparam int CNT_MAX   = (1 << COUNT_W) - 1;
    localparam int BIG       = 1 << 30;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH-1:0]    trig_p = '0;
    logic [NUM_CH-1:0]    trig_n = '0;
    logic                 enable = 1'b1;
    logic [WINDOW_W-1:0]  window = 4'd4;
    logic [MULT_W-1:0]    threshold = 3'd2;
    logic [HOLDOFF_W-1:0] holdoff = '0;
    logic                 trig_o;
    logic [NUM_CH-1:0]    trig_pattern_o;
    logic [MULT_W-1:0]    multiplicity_o;
    logic                 busy_o;
    logic [COUNT_W-1:0]   trig_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    int n_busy   = 0;

    always #5 clk = ~clk;

    trigger_multiplicity_coinc #(
        .NUM_CH    (NUM_CH),
        .MULT_W    (MULT_W),
        .WINDOW_W  (WINDOW_W),
        .HOLDOFF_W (HOLDOFF_W),
        .COUNT_W   (COUNT_W)
    ) dut (
        .fast_clk_i     (clk),
        .rst_n_i        (rst_n),
        .trig_p_i       (trig_p),
        .trig_n_i       (trig_n),
        .enable_i       (enable),
        .window_i       (window),
        .threshold_i    (threshold),
        .holdoff_i      (holdoff),
        .trig_o         (trig_o),
        .trig_pattern_o (trig_pattern_o),
        .multiplicity_o (multiplicity_o),
        .busy_o         (busy_o),
        .trig_count_o   (trig_count_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Time t counts clock edges. A channel is open after edge s iff
    // s < close[ch]. The station is busy after edge s iff s < idle_at;
    // the trigger pulse is the cycle after edge fire_edge.
    int               t;
    int               close_t [NUM_CH];
    logic [NUM_CH-1:0] lv1, lv2;
    int               m_mult;
    int               fire_edge;
    int               idle_at;
    logic [NUM_CH-1:0] m_pat;
    int               m_mul;
    int               m_cnt;
    logic [NUM_CH-1:0] popen;
    logic [NUM_CH-1:0] rise;
    bit               was_fire, was_idle;
    int               win_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            for (int i = 0; i < NUM_CH; i++) close_t[i] = 0;
            lv1 = '0; lv2 = '0;
            m_mult = 0; fire_edge = -100; idle_at = 0;
            m_pat = '0; m_mul = 0; m_cnt = 0;
        end else begin
            t = t + 1;
            for (int i = 0; i < NUM_CH; i++) popen[i] = ((t - 1) < close_t[i]);
            was_fire = (fire_edge == t - 1);
            was_idle = ((t - 1) >= idle_at);
            rise     = lv1 & ~lv2;
            win_len  = (window == 0) ? 1 : int'(window);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!enable || was_fire) close_t[i] = t;
                else if (rise[i])       close_t[i] = t + win_len;
            end
            if (was_idle && enable && threshold != 0 && m_mult >= int'(threshold)) begin
                fire_edge = t;
                idle_at   = BIG;
                m_pat     = popen;
                m_mul     = m_mult;
                if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1;
            end
            if (was_fire) idle_at = t + int'(holdoff) + 1;
            m_mult = $countones(popen);
            lv2 = lv1;
            lv1 = trig_p | trig_n;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("trig_o",         int'(trig_o),         int'(fire_edge == t));
            chk("busy_o",         int'(busy_o),         int'(t < idle_at));
            chk("trig_pattern_o", int'(trig_pattern_o), int'(m_pat));
            chk("multiplicity_o", int'(multiplicity_o), m_mul);
            chk("trig_count_o",   int'(trig_count_o),   m_cnt);
            if (trig_o) n_pulse++;
            if (busy_o) n_busy++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] n);
        trig_p = p;
        trig_n = n;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step('0, '0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_trig"},    int'(trig_o), 0);
        chk({tag, "_busy"},    int'(busy_o), 0);
        chk({tag, "_pattern"}, int'(trig_pattern_o), 0);
        chk({tag, "_mult"},    int'(multiplicity_o), 0);
        chk({tag, "_count"},   int'(trig_count_o), 0);
    endtask

    task automatic do_reset();
        trig_p = '0;
        trig_n = '0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
    endtask

    int base;
    int base_busy;

    initial begin
        // 1: two overlapping windows reach threshold 2
        enable = 1; window = 4; threshold = 2; holdoff = 0;
        do_reset();
        base = n_pulse;
        step(4'b0001, '0); step(4'b0001, '0); step(4'b0101, '0);
        step(4'b0100, '0); step(4'b0100, '0);
        idle(12);
        chk("t1_pulses",  n_pulse - base, 1);
        chk("t1_pattern", int'(trig_pattern_o), 4'b0101);
        chk("t1_mult",    int'(multiplicity_o), 2);
        chk("t1_count",   int'(trig_count_o), 1);

        // 2: hits too far apart for a 4-cycle window
        do_reset();
        base = n_pulse;
        step(4'b0001, '0); idle(4); step(4'b0010, '0); idle(10);
        chk("t2_pulses", n_pulse - base, 0);
        chk("t2_count",  int'(trig_count_o), 0);

        // 3: p then n on the same channel is one channel; n-only on ch3 counts
        do_reset();
        base = n_pulse;
        step(4'b0001, '0); step(4'b0001, '0); step(4'b0001, '0);
        step('0, 4'b0001); idle(10);
        chk("t3_single_ch", n_pulse - base, 0);
        step(4'b0001, 4'b1000); idle(10);
        chk("t3_pulses",  n_pulse - base, 1);
        chk("t3_pattern", int'(trig_pattern_o), 4'b1001);

        // 4: holdoff blocks the repeat, busy spans FIRE plus holdoff+1 cycles
        threshold = 4; holdoff = 10;
        do_reset();
        base = n_pulse; base_busy = n_busy;
        step(4'b1111, '0); idle(5); step(4'b1111, '0); idle(30);
        chk("t4_pulses", n_pulse - base, 1);
        chk("t4_busy",   n_busy - base_busy, 12);
        chk("t4_idle",   int'(busy_o), 0);
        step(4'b1111, '0); idle(8);
        chk("t4_pulses2", n_pulse - base, 2);
        chk("t4_count",   int'(trig_count_o), 2);
        chk("t4_mult",    int'(multiplicity_o), 4);
        idle(15);

        // 5: threshold 0 disables, enable low disables, then arm
        threshold = 0; holdoff = 0;
        do_reset();
        base = n_pulse;
        step(4'b1111, '0); idle(8);
        chk("t5_thr0", n_pulse - base, 0);
        threshold = 1; enable = 0;
        step(4'b0010, '0); idle(8);
        chk("t5_disabled", n_pulse - base, 0);
        enable = 1;
        step(4'b0010, '0); idle(8);
        chk("t5_pulses",  n_pulse - base, 1);
        chk("t5_pattern", int'(trig_pattern_o), 4'b0010);
        chk("t5_mult",    int'(multiplicity_o), 1);

        // 6: asynchronous reset mid-holdoff, then a normal trigger with latency check
        threshold = 2; holdoff = 20;
        do_reset();
        step(4'b0011, '0); idle(6);
        chk("t6_busy_before", int'(busy_o), 1);
        chk("t6_count_before", int'(trig_count_o), 1);
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("async_rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        holdoff = 0;
        base = n_pulse;
        step(4'b0101, '0); idle(2);
        chk("t6_lat_early", int'(trig_o), 0);
        idle(1);
        chk("t6_lat_fire", int'(trig_o), 1);
        idle(6);
        chk("t6_pulses",  n_pulse - base, 1);
        chk("t6_pattern", int'(trig_pattern_o), 4'b0101);
        chk("t6_count",   int'(trig_count_o), 1);

        // Randomized traffic and configuration, checked by the model
        for (int blk = 0; blk < 6; blk++) begin
            enable    = ($urandom_range(0, 7) != 0);
            window    = WINDOW_W'($urandom_range(0, 15));
            threshold = MULT_W'($urandom_range(0, 7));
            holdoff   = HOLDOFF_W'($urandom_range(0, 12));
            for (int c = 0; c < 300; c++) begin
                logic [NUM_CH-1:0] rp, rn;
                for (int b = 0; b < NUM_CH; b++) begin
                    rp[b] = ($urandom_range(0, 6) == 0);
                    rn[b] = ($urandom_range(0, 9) == 0);
                end
                step(rp, rn);
            end
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
